regfile_wb_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the RV32I integer register file. It shares the file's single write port between the in-order pipeline writeback (WB0) and the long-latency unit writeback (WB1, e.g. mul/div or load miss). It tracks registers with pending long-latency results and generates the issue stall for RAW and WAW hazards on them. It sits between the decode/issue stage, the two writeback sources and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the pipeline writeback (WB0) and a
// buffered long-latency writeback (WB1), and scoreboards pending long results for issue stalls.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  input  logic            issue_long_i,
  input  logic [4:0]      issue_rs1_i,
  input  logic [4:0]      issue_rs2_i,
  input  logic [4:0]      issue_rd_i,
  output logic            stall_o,
  input  logic            wb0_valid_i,
  input  logic [4:0]      wb0_rd_i,
  input  logic [XLEN-1:0] wb0_data_i,
  input  logic            wb1_valid_i,
  output logic            wb1_ready_o,
  input  logic [4:0]      wb1_rd_i,
  input  logic [XLEN-1:0] wb1_data_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_wdata_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      fifo_rd_mem   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   fifo_level;
  logic            fifo_empty;
  logic            fifo_full;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  logic [CW-1:0]   starve_cnt_reg;
  logic [CW-1:0]   starve_cnt_inc;
  logic            throttle_reg;
  logic            throttle;

  logic            busy_reg [1:31];
  logic [31:0]     busy;

  logic            wb0_own;
  logic            enq;
  logic            pop;
  logic            haz;
  logic            busy_set;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fifo_level = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (fifo_level == PW'(FIFO_DEPTH));
  assign head_rd    = fifo_rd_mem[rd_ptr_reg[AW-1:0]];
  assign head_data  = fifo_data_mem[rd_ptr_reg[AW-1:0]];

  assign wb1_ready_o = !fifo_full;
  assign enq         = wb1_valid_i && wb1_ready_o && (wb1_rd_i != 5'd0);
  assign wb0_own     = wb0_valid_i && (wb0_rd_i != 5'd0);
  assign pop         = !wb0_own && !fifo_empty;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_rd_o    = 5'd0;
    rf_wdata_o = '0;
    if (wb0_own) begin
      rf_we_o    = 1'b1;
      rf_rd_o    = wb0_rd_i;
      rf_wdata_o = wb0_data_i;
    end else if (!fifo_empty) begin
      rf_we_o    = 1'b1;
      rf_rd_o    = head_rd;
      rf_wdata_o = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd_mem[wr_ptr_reg[AW-1:0]]   <= wb1_rd_i;
      fifo_data_mem[wr_ptr_reg[AW-1:0]] <= wb1_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Counter saturates at the limit; throttle latches once the limit is reached.
  assign starve_cnt_inc = (starve_cnt_reg == CW'(STARVE_LIMIT)) ? starve_cnt_reg
                                                                : starve_cnt_reg + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
      throttle_reg   <= 1'b0;
    end else begin
      if (fifo_empty || pop) begin
        starve_cnt_reg <= '0;
      end else if (wb0_own) begin
        starve_cnt_reg <= starve_cnt_inc;
      end
      if (fifo_empty) begin
        throttle_reg <= 1'b0;
      end else if (wb0_own && (starve_cnt_inc == CW'(STARVE_LIMIT))) begin
        throttle_reg <= 1'b1;
      end
    end
  end

  // Masking with the live empty flag drops the throttle as soon as the last entry commits.
  assign throttle = throttle_reg && !fifo_empty;

  always_comb begin
    busy = '0;
    for (int i = 1; i < 32; i++) busy[i] = busy_reg[i];
  end

  assign haz      = issue_valid_i && (busy[issue_rs1_i] || busy[issue_rs2_i] || busy[issue_rd_i]);
  assign stall_o  = haz || (issue_valid_i && throttle);
  assign busy_set = issue_valid_i && issue_long_i && !stall_o && (issue_rd_i != 5'd0);

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          busy_reg[gi] <= 1'b0;
        end else if (busy_set && (issue_rd_i == 5'(gi))) begin
          busy_reg[gi] <= 1'b1;
        end else if (pop && (head_rd == 5'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a per-cycle vector table plus
// hand-written reset-mid-run and starvation sequences.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_i, issue_long_i;
  logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i;
  logic        stall_o;
  logic        wb0_valid_i;
  logic [4:0]  wb0_rd_i;
  logic [31:0] wb0_data_i;
  logic        wb1_valid_i;
  logic        wb1_ready_o;
  logic [4:0]  wb1_rd_i;
  logic [31:0] wb1_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_long_i(issue_long_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .issue_rd_i(issue_rd_i),
    .stall_o(stall_o),
    .wb0_valid_i(wb0_valid_i), .wb0_rd_i(wb0_rd_i), .wb0_data_i(wb0_data_i),
    .wb1_valid_i(wb1_valid_i), .wb1_ready_o(wb1_ready_o),
    .wb1_rd_i(wb1_rd_i), .wb1_data_i(wb1_data_i),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o)
  );

  typedef struct {
    logic        iv, il;
    logic [4:0]  rs1, rs2, rd;
    logic        w0v;
    logic [4:0]  w0rd;
    logic [31:0] w0d;
    logic        w1v;
    logic [4:0]  w1rd;
    logic [31:0] w1d;
    logic        e_stall, e_rdy, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(
    input logic iv, input logic il, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic w0v, input logic [4:0] w0rd, input logic [31:0] w0d,
    input logic w1v, input logic [4:0] w1rd, input logic [31:0] w1d,
    input logic es, input logic er, input logic ew, input logic [4:0] erd, input logic [31:0] ed);
    vec_t v;
    v.iv = iv; v.il = il; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.w0v = w0v; v.w0rd = w0rd; v.w0d = w0d;
    v.w1v = w1v; v.w1rd = w1rd; v.w1d = w1d;
    v.e_stall = es; v.e_rdy = er; v.e_we = ew; v.e_rd = erd; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic set_idle();
    issue_valid_i = 1'b0; issue_long_i = 1'b0;
    issue_rs1_i = 5'd0; issue_rs2_i = 5'd0; issue_rd_i = 5'd0;
    wb0_valid_i = 1'b0; wb0_rd_i = 5'd0; wb0_data_i = 32'd0;
    wb1_valid_i = 1'b0; wb1_rd_i = 5'd0; wb1_data_i = 32'd0;
  endtask

  task automatic set_issue(input logic iv, input logic il, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd);
    issue_valid_i = iv; issue_long_i = il;
    issue_rs1_i = rs1; issue_rs2_i = rs2; issue_rd_i = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    #2;
    chk("rst_stall", 0, 32'(stall_o), 32'd0);
    chk("rst_ready", 0, 32'(wb1_ready_o), 32'd1);
    chk("rst_we", 0, 32'(rf_we_o), 32'd0);
    chk("rst_rd", 0, 32'(rf_rd_o), 32'd0);
    chk("rst_wdata", 0, rf_wdata_o, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();

    //            iv il rs1 rs2 rd  w0v w0rd w0d        w1v w1rd w1d          st rdy we rd  data
    vecs[0]  = mk(0, 0, 0,  0,  0,  0,  0,   0,         0,  0,   0,           0, 1, 0, 0,  0);
    vecs[1]  = mk(1, 1, 1,  2,  5,  0,  0,   0,         0,  0,   0,           0, 1, 0, 0,  0);
    vecs[2]  = mk(1, 0, 5,  0,  6,  0,  0,   0,         0,  0,   0,           1, 1, 0, 0,  0);
    vecs[3]  = mk(1, 0, 5,  0,  6,  0,  0,   0,         1,  5,   32'hDEADBEEF, 1, 1, 0, 0,  0);
    vecs[4]  = mk(1, 0, 5,  0,  6,  0,  0,   0,         0,  0,   0,           1, 1, 1, 5,  32'hDEADBEEF);
    vecs[5]  = mk(1, 0, 5,  0,  6,  0,  0,   0,         0,  0,   0,           0, 1, 0, 0,  0);
    vecs[6]  = mk(0, 0, 0,  0,  0,  1,  3,   32'h11,    1,  7,   32'h22,      0, 1, 1, 3,  32'h11);
    vecs[7]  = mk(0, 0, 0,  0,  0,  0,  0,   0,         0,  0,   0,           0, 1, 1, 7,  32'h22);
    vecs[8]  = mk(0, 0, 0,  0,  0,  0,  0,   0,         0,  0,   0,           0, 1, 0, 0,  0);
    vecs[9]  = mk(1, 1, 0,  0,  0,  0,  0,   0,         0,  0,   0,           0, 1, 0, 0,  0);
    vecs[10] = mk(1, 0, 0,  0,  0,  0,  0,   0,         1,  0,   32'h55,      0, 1, 0, 0,  0);
    vecs[11] = mk(0, 0, 0,  0,  0,  0,  0,   0,         0,  0,   0,           0, 1, 0, 0,  0);
    vecs[12] = mk(0, 0, 0,  0,  0,  1,  1,   32'hA1,    1,  8,   32'h81,      0, 1, 1, 1,  32'hA1);
    vecs[13] = mk(0, 0, 0,  0,  0,  1,  2,   32'hA2,    1,  9,   32'h91,      0, 1, 1, 2,  32'hA2);
    vecs[14] = mk(0, 0, 0,  0,  0,  1,  3,   32'hA3,    1,  10,  32'hA0,      0, 0, 1, 3,  32'hA3);
    vecs[15] = mk(0, 0, 0,  0,  0,  1,  0,   32'hFF,    1,  10,  32'hA0,      0, 0, 1, 8,  32'h81);
    vecs[16] = mk(0, 0, 0,  0,  0,  0,  0,   0,         1,  10,  32'hA0,      0, 1, 1, 9,  32'h91);
    vecs[17] = mk(0, 0, 0,  0,  0,  0,  0,   0,         0,  0,   0,           0, 1, 1, 10, 32'hA0);
    vecs[18] = mk(0, 0, 0,  0,  0,  0,  0,   0,         0,  0,   0,           0, 1, 0, 0,  0);

    for (int i = 0; i < 19; i++) begin
      set_issue(vecs[i].iv, vecs[i].il, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      wb0_valid_i = vecs[i].w0v; wb0_rd_i = vecs[i].w0rd; wb0_data_i = vecs[i].w0d;
      wb1_valid_i = vecs[i].w1v; wb1_rd_i = vecs[i].w1rd; wb1_data_i = vecs[i].w1d;
      #1;
      $display("vec %0d stall=%0b ready=%0b we=%0b rd=%0d wdata=%h",
               i, stall_o, wb1_ready_o, rf_we_o, rf_rd_o, rf_wdata_o);
      chk("vec_stall", i, 32'(stall_o), 32'(vecs[i].e_stall));
      chk("vec_ready", i, 32'(wb1_ready_o), 32'(vecs[i].e_rdy));
      chk("vec_we", i, 32'(rf_we_o), 32'(vecs[i].e_we));
      chk("vec_rd", i, 32'(rf_rd_o), 32'(vecs[i].e_rd));
      chk("vec_wdata", i, rf_wdata_o, vecs[i].e_data);
      next_cycle();
    end

    // Reset mid-run with busy[5] set and two buffered WB1 results.
    set_idle();
    set_issue(1, 1, 1, 2, 5);
    wb0_valid_i = 1'b1; wb0_rd_i = 5'd1; wb0_data_i = 32'h1;
    #1;
    chk("mr_issue_stall", 0, 32'(stall_o), 32'd0);
    next_cycle();
    set_issue(0, 0, 0, 0, 0);
    wb1_valid_i = 1'b1; wb1_rd_i = 5'd20; wb1_data_i = 32'h20;
    next_cycle();
    wb1_rd_i = 5'd21; wb1_data_i = 32'h21;
    next_cycle();
    wb1_valid_i = 1'b0;
    #1;
    chk("mr_full_ready", 0, 32'(wb1_ready_o), 32'd0);
    chk("mr_wb0_rd", 0, 32'(rf_rd_o), 32'd1);
    set_idle();
    rst_n = 1'b0;
    #1;
    $display("midreset ready=%0b we=%0b rd=%0d", wb1_ready_o, rf_we_o, rf_rd_o);
    chk("mr_rst_ready", 0, 32'(wb1_ready_o), 32'd1);
    chk("mr_rst_we", 0, 32'(rf_we_o), 32'd0);
    chk("mr_rst_rd", 0, 32'(rf_rd_o), 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    set_issue(1, 0, 5, 0, 5);
    #1;
    $display("postreset stall=%0b ready=%0b we=%0b", stall_o, wb1_ready_o, rf_we_o);
    chk("mr_post_stall", 0, 32'(stall_o), 32'd0);
    chk("mr_post_we", 0, 32'(rf_we_o), 32'd0);
    chk("mr_post_ready", 0, 32'(wb1_ready_o), 32'd1);
    next_cycle();

    // Starvation: WB0 owns the port every cycle while x12 sits in the FIFO.
    set_idle();
    set_issue(1, 1, 0, 0, 12);
    #1;
    chk("sv_issue_stall", 0, 32'(stall_o), 32'd0);
    next_cycle();
    set_issue(1, 0, 1, 2, 3);
    wb0_valid_i = 1'b1; wb0_rd_i = 5'd1; wb0_data_i = 32'h100;
    wb1_valid_i = 1'b1; wb1_rd_i = 5'd12; wb1_data_i = 32'hC;
    #1;
    chk("sv_s0_stall", 0, 32'(stall_o), 32'd0);
    next_cycle();
    wb1_valid_i = 1'b0;
    for (int s = 1; s <= 7; s++) begin
      wb0_data_i = 32'h100 + 32'(s);
      #1;
      $display("starve %0d stall=%0b we=%0b rd=%0d", s, stall_o, rf_we_o, rf_rd_o);
      chk("sv_stall", s, 32'(stall_o), (s >= 5) ? 32'd1 : 32'd0);
      chk("sv_rd", s, 32'(rf_rd_o), 32'd1);
      next_cycle();
    end
    wb0_valid_i = 1'b0; wb0_rd_i = 5'd0;
    #1;
    chk("sv_drain_stall", 8, 32'(stall_o), 32'd1);
    chk("sv_drain_we", 8, 32'(rf_we_o), 32'd1);
    chk("sv_drain_rd", 8, 32'(rf_rd_o), 32'd12);
    chk("sv_drain_data", 8, rf_wdata_o, 32'hC);
    next_cycle();
    set_issue(1, 0, 12, 0, 4);
    #1;
    $display("starve end stall=%0b we=%0b", stall_o, rf_we_o);
    chk("sv_end_stall", 9, 32'(stall_o), 32'd0);
    chk("sv_end_we", 9, 32'(rf_we_o), 32'd0);
    next_cycle();

    set_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
